// File: rtl/cb_param_chain.sv
// cb_param_chain: parametrised connection block between a routing channel
// (G) and the logic-block pins (x inputs, q outputs). Switch enables arrive
// over a daisy-chained serial bus into a shadow register and are copied to
// the active register only on commit, so routing never glitches mid-load.
// Optional feature macro: CB_CFG_PARITY_EN (adds a trailing even-parity bit
// to the serial stream and a cfg_err output).
module cb_param_chain #(
  parameter int N_TRACKS = 8,
  parameter int N_IN     = 4,
  parameter int N_OUT    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                prgm_b,
  input  logic                cb_prgm_b,
  input  logic                cb_prgm_b_in,
  output logic                cb_prgm_b_out,
  input  logic                bit_in_CB,
  output logic [N_IN-1:0]     x,
  input  logic [N_OUT-1:0]    q,
  inout  wire  [N_TRACKS-1:0] G,
  output logic                cfg_done,
  output logic                cfg_conflict
`ifdef CB_CFG_PARITY_EN
  ,
  output logic                cfg_err
`endif
);

  localparam int CFG_BITS = (N_IN + N_OUT) * N_TRACKS;
`ifdef CB_CFG_PARITY_EN
  localparam int SHIFT_BITS = CFG_BITS + 1;
`else
  localparam int SHIFT_BITS = CFG_BITS;
`endif
  localparam int CNT_W = $clog2(SHIFT_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, COMMIT} state_t;

  state_t                state;
  logic [SHIFT_BITS-1:0] shadow;
  logic [CFG_BITS-1:0]   active;
  logic [CNT_W-1:0]      count;
  logic                  load_full;

  logic                  shift_en;
  logic                  last_bit;
  logic                  parity_ok;
  logic [CFG_BITS-1:0]   shadow_cfg;
  logic [CFG_BITS-1:0]   commit_cfg;
  logic                  next_conflict;

  // A bit is taken only while this block is selected and holds the token.
  assign shift_en = (state == SHIFT) && !cb_prgm_b && !cb_prgm_b_in;
  assign last_bit = shift_en && (count == CNT_W'(SHIFT_BITS - 1));

  // The first bit shifted in ends up at the top, so the config field is the
  // upper CFG_BITS of the shadow; with parity the check bit sits at bit 0.
  assign shadow_cfg = shadow[SHIFT_BITS-1 -: CFG_BITS];
`ifdef CB_CFG_PARITY_EN
  assign parity_ok = ~(^shadow);
`else
  assign parity_ok = 1'b1;
`endif

  // An incomplete load keeps the old config; a bad-parity load switches all off.
  assign commit_cfg = load_full ? (parity_ok ? shadow_cfg : '0) : active;

  // Per-track view of the q enables, both for the live and the pending config.
  logic [N_TRACKS-1:0][N_OUT-1:0] out_sel;
  logic [N_TRACKS-1:0][N_OUT-1:0] out_pick;
  logic [N_TRACKS-1:0][N_OUT-1:0] next_sel;
  logic [N_TRACKS-1:0]            next_multi;

  for (genvar t = 0; t < N_TRACKS; t++) begin : g_track
    for (genvar j = 0; j < N_OUT; j++) begin : g_out
      assign out_sel[t][j]  = active[N_TRACKS*(N_IN+j)+t];
      assign next_sel[t][j] = commit_cfg[N_TRACKS*(N_IN+j)+t];
    end
    // Lowest enabled q wins the track, so contention never reaches G.
    assign out_pick[t]   = out_sel[t] & (~out_sel[t] + 1'b1);
    assign G[t]          = (|out_sel[t]) ? (|(out_pick[t] & q)) : 1'bz;
    // Clearing the lowest set bit leaves something only if two or more are set.
    assign next_multi[t] = |(next_sel[t] & (next_sel[t] - 1'b1));
  end

  assign next_conflict = |next_multi;

  // Each input pin takes the lowest-numbered enabled track, or 0 if none.
  logic [N_IN-1:0][N_TRACKS-1:0] track_sel;
  logic [N_IN-1:0][N_TRACKS-1:0] track_pick;

  for (genvar i = 0; i < N_IN; i++) begin : g_pin
    assign track_sel[i]  = active[N_TRACKS*i +: N_TRACKS];
    assign track_pick[i] = track_sel[i] & (~track_sel[i] + 1'b1);
    assign x[i]          = |(track_pick[i] & G);
  end

  // Configuration FSM: load the shadow, hand the token on, then commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      shadow        <= '0;
      active        <= '0;
      count         <= '0;
      load_full     <= 1'b0;
      cb_prgm_b_out <= 1'b1;
      cfg_done      <= 1'b0;
      cfg_conflict  <= 1'b0;
`ifdef CB_CFG_PARITY_EN
      cfg_err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!prgm_b && !cb_prgm_b) begin
            state     <= SHIFT;
            count     <= '0;
            load_full <= 1'b0;
            cfg_done  <= 1'b0;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            shadow <= {shadow[SHIFT_BITS-2:0], bit_in_CB};
            count  <= count + 1'b1;
          end
          if (prgm_b) begin
            state     <= COMMIT;
            load_full <= last_bit;
            if (last_bit) begin
              cfg_done <= 1'b1;
            end
          end else if (last_bit) begin
            state         <= DONE;
            load_full     <= 1'b1;
            cfg_done      <= 1'b1;
            cb_prgm_b_out <= 1'b0;
          end
        end
        DONE: begin
          if (prgm_b) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          active        <= commit_cfg;
          cfg_conflict  <= next_conflict;
          cb_prgm_b_out <= 1'b1;
          count         <= '0;
          state         <= IDLE;
`ifdef CB_CFG_PARITY_EN
          if (load_full) begin
            cfg_err <= !parity_ok;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cb_param_chain.md
Name: cb_param_chain

Overview:
- Parametrised connection block joining N_IN logic-block input pins and N_OUT logic-block output pins to an N_TRACKS routing channel.
- Switch enables are loaded over a daisy-chained serial configuration bus with token hand-off to the next block.
- A shadow/active register pair holds the enables; the active copy updates only on commit, so routing stays glitch-free while the chain is being programmed.
- Sits between routing channels and the CLB pins in the fabric tile.

Parameters:
- N_TRACKS, 8, number of routing tracks G.
- N_IN, 4, number of track-to-pin inputs x.
- N_OUT, 2, number of pin-to-track outputs q.
- Derived localparam CFG_BITS = (N_IN+N_OUT)*N_TRACKS; default is 48.

Ports:
- clk  input  1  configuration clock.
- reset  input  1  asynchronous, active-low reset.
- prgm_b  input  1  global program mode, active-low.
- cb_prgm_b  input  1  local block select, active-low.
- cb_prgm_b_in  input  1  chain token from the previous block, active-low (0 = this block's turn).
- cb_prgm_b_out  output  1  chain token to the next block, active-low.
- bit_in_CB  input  1  serial configuration data.
- x  output  N_IN  pins driven from tracks.
- q  input  N_OUT  pins driving tracks.
- G  inout  N_TRACKS  routing tracks.
- cfg_done  output  1  high once this block has received all CFG_BITS.
- cfg_conflict  output  1  more than one q enabled onto the same track in the active config.

Behaviour:
- Config layout:
  - bit N_TRACKS*i+t: x[i] takes G[t].
  - bit N_TRACKS*(N_IN+j)+t: q[j] drives G[t].
- Shift rule: shadow <= {shadow[CFG_BITS-2:0], bit_in_CB}, so the first bit shifted in lands at CFG_BITS-1.
- Bit counter width is clog2(CFG_BITS+1).
- Reset (reset=0, async):
  - state=IDLE, shadow=0, active=0, counter=0.
  - cb_prgm_b_out=1, cfg_done=0, cfg_conflict=0.
  - x=0; all G released (Z).
- States: IDLE, SHIFT, DONE, COMMIT.
- IDLE:
  - prgm_b=0 and cb_prgm_b=0 -> SHIFT, counter cleared.
  - Stays in IDLE otherwise.
- SHIFT:
  - Each clk with cb_prgm_b_in=0: shift one bit, counter+1.
  - cb_prgm_b_in=1 stalls the shift and holds the counter.
  - When the CFG_BITS-th bit is captured -> DONE on the same edge.
- DONE:
  - cb_prgm_b_out=0, registered: asserted on the first cycle in DONE.
  - cfg_done=1; further bit_in_CB ignored.
- Leaving SHIFT or DONE:
  - prgm_b rising to 1 in SHIFT or DONE -> COMMIT.
  - From SHIFT (incomplete load): commit is suppressed, active is unchanged, cfg_done stays 0.
- COMMIT (one cycle):
  - active <= shadow when the load was complete.
  - cb_prgm_b_out <= 1, counter <= 0.
  - cfg_conflict recomputed from the new active config.
  - -> IDLE.
- cb_prgm_b=1 mid-SHIFT: freeze (no shift) until it returns to 0; the state is not left.
- prgm_b=0 again while in DONE: remain in DONE.
- Datapath (combinational from active):
  - x[i] = G[t] for the lowest t whose enable is set; 0 if none set.
  - G[t] = q[j] for the lowest j whose enable is set, else Z.
  - cfg_conflict = 1 if any track has 2 or more q enables set (priority resolution still applies, so no X on G).
- Simultaneous events: reset dominates everything. When prgm_b rises on the same edge as the final bit, that bit is captured, the load counts as complete, and the next state is COMMIT.

Optional Feature:
- Macro: CB_CFG_PARITY_EN.
- With the macro defined:
  - CFG_BITS+1 bits are shifted.
  - The final bit is even parity over the preceding CFG_BITS bits.
  - In COMMIT on a parity mismatch: active is cleared to 0 and extra output cfg_err=1, held until the next good commit or reset.
- Without the macro: no parity bit, no cfg_err port, and the commit is unconditional on a complete load.

Test Plan (defaults):
- Reset: drive reset=0 mid-SHIFT after 20 bits -> next cycle x=0, G all Z, cb_prgm_b_out=1, cfg_done=0, counter=0.
- Basic route: shift 48 bits setting x[0]<-G[3] and q[1]->G[5], then release prgm_b.
  - During shifting: x is unchanged.
  - After COMMIT: driving G[3]=1 gives x[0]=1; q[1]=1 gives G[5]=1; cfg_conflict=0.
- Chain: two blocks with token wired.
  - First block asserts cb_prgm_b_out=0 exactly after its 48th bit.
  - Second block captures bits 49..96; its x[2]<-G[7] route is verified after commit.
- Stall: toggle cb_prgm_b_in=1 for 5 cycles mid-load -> those 5 bits are not counted; cfg_done asserts only after 48 counted bits.
- Conflict: enable q[0] and q[1] both onto G[2] -> cfg_conflict=1 and G[2] follows q[0].
- Incomplete load: release prgm_b after 30 bits -> active unchanged from the previous config, cfg_done=0.
  - With CB_CFG_PARITY_EN, a bad parity bit gives cfg_err=1 and all switches off.
